bus_memory_slave: RTL

- On-chip word memory attached as a slave to the shared bus driven by the jtag_support DMA master; it is the downstream consumer of that master's transactions.
- Accepts single and burst reads and writes with byte enables, stalls writes via busy, and flags bad addresses via error.
- All bus outputs are zero when not driving, so the slave can share a wired-OR bus.

---
 rtl/bus_memory_slave_if.sv | 29 ++
 rtl/bus_memory_slave.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_slave_if.sv
// Shared-bus signal bundle between the DMA master and the memory slave.
// Signal names are given from the slave's point of view (IN = toward slave).
interface bus_memory_slave_if;
    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic        read_n_writeIN;
    logic        begin_transactionIN;
    logic        end_transactionIN;
    logic        data_validIN;
    logic        busyIN;
    logic [31:0] address_dataOUT;
    logic        end_transactionOUT;
    logic        data_validOUT;
    logic        busyOUT;
    logic        errorOUT;

    modport slave (
        input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
               begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        output address_dataOUT, end_transactionOUT, data_validOUT, busyOUT, errorOUT
    );

    modport master (
        output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
               begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        input  address_dataOUT, end_transactionOUT, data_validOUT, busyOUT, errorOUT
    );
endinterface

// File: rtl/bus_memory_slave.sv
// On-chip word memory slave on the shared DMA bus: single/burst reads and
// writes with byte enables, write stalls via busy, error on misaligned access.
module bus_memory_slave #(
    parameter logic [31:0] BASE_ADDRESS      = 32'h5555_0000,
    parameter int unsigned ADDR_BITS         = 8,
    parameter int unsigned READ_WAIT_STATES  = 2,
    parameter int unsigned WRITE_WAIT_STATES = 1
) (
    input  logic              system_clock,
    input  logic              system_reset,
    bus_memory_slave_if.slave bus
);
    localparam int unsigned SIZE_WORDS = 2 ** ADDR_BITS;
    localparam int unsigned TAG_LSB    = ADDR_BITS + 2;
    localparam logic [3:0]  RWAIT_LAST = 4'(READ_WAIT_STATES - 1);
    localparam logic [3:0]  WWAIT_LAST = 4'(WRITE_WAIT_STATES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RWAIT, S_READ, S_ENDR, S_WRITE, S_ERROR, S_DRAIN
    } state_t;

    logic [31:0] mem [SIZE_WORDS];

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [3:0]             be_q, be_d;
    logic [7:0]             burst_q, burst_d;
    logic                   rnw_q, rnw_d;
    logic [8:0]             beat_q, beat_d;
    logic [3:0]             wait_q, wait_d;
    logic [31:0]            data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   end_q, end_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   mem_we_c;
    logic                   selected_c;
    logic                   accept_c;
    logic [ADDR_BITS-1:0]   begin_idx_c;
    logic [ADDR_BITS-1:0]   idx_inc_c;

    assign selected_c  = bus.address_dataIN[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB];
    assign begin_idx_c = bus.address_dataIN[TAG_LSB-1:2];
    assign idx_inc_c   = idx_q + ADDR_BITS'(1);
    assign accept_c    = bus.data_validIN && !busy_q;

    // State and registered bus outputs
    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            be_q    <= '0;
            burst_q <= '0;
            rnw_q   <= 1'b0;
            beat_q  <= '0;
            wait_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            burst_q <= burst_d;
            rnw_q   <= rnw_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output logic; outputs fall to zero unless driven
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        be_d     = be_q;
        burst_d  = burst_q;
        rnw_d    = rnw_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        data_d   = '0;
        dv_d     = 1'b0;
        end_d    = 1'b0;
        busy_d   = 1'b0;
        err_d    = 1'b0;
        mem_we_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.begin_transactionIN && selected_c) begin
                    idx_d   = begin_idx_c;
                    be_d    = bus.byte_enableIN;
                    burst_d = bus.burst_sizeIN;
                    rnw_d   = bus.read_n_writeIN;
                    beat_d  = '0;
                    wait_d  = '0;
                    if (bus.address_dataIN[1:0] != 2'b00) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else if (bus.read_n_writeIN) begin
                        if (READ_WAIT_STATES == 0) begin
                            state_d = S_READ;
                            dv_d    = 1'b1;
                            data_d  = mem[begin_idx_c];
                        end else begin
                            state_d = S_RWAIT;
                        end
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_RWAIT: begin
                if (bus.end_transactionIN) begin
                    state_d = S_IDLE;
                end else if (wait_q == RWAIT_LAST) begin
                    state_d = S_READ;
                    dv_d    = 1'b1;
                    data_d  = mem[idx_q];
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_READ: begin
                if (bus.end_transactionIN) begin
                    state_d = S_IDLE;
                end else if (bus.busyIN) begin
                    dv_d   = 1'b1;
                    data_d = data_q;
                end else if (beat_q == {1'b0, burst_q}) begin
                    state_d = S_ENDR;
                    end_d   = 1'b1;
                end else begin
                    beat_d = beat_q + 9'd1;
                    idx_d  = idx_inc_c;
                    dv_d   = 1'b1;
                    data_d = mem[idx_inc_c];
                end
            end
            S_ENDR: begin
                state_d = S_IDLE;
            end
            S_WRITE: begin
                // beat_q only advances on stored beats, so it saturates at burst+1
                if (accept_c && (beat_q <= {1'b0, burst_q})) begin
                    mem_we_c = 1'b1;
                    idx_d    = idx_inc_c;
                    beat_d   = beat_q + 9'd1;
                end
                if (accept_c) begin
                    busy_d = WRITE_WAIT_STATES != 0;
                    wait_d = '0;
                end else if (busy_q) begin
                    busy_d = wait_q != WWAIT_LAST;
                    wait_d = wait_q + 4'd1;
                end
                if (bus.end_transactionIN) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_ERROR: begin
                state_d = (!rnw_q && !bus.end_transactionIN) ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (bus.end_transactionIN) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte-lane memory write; contents survive reset
    always_ff @(posedge system_clock) begin
        if (mem_we_c) begin
            for (int k = 0; k < 4; k++) begin
                if (be_q[k]) mem[idx_q][8*k +: 8] <= bus.address_dataIN[8*k +: 8];
            end
        end
    end

    assign bus.address_dataOUT    = data_q;
    assign bus.data_validOUT      = dv_q;
    assign bus.end_transactionOUT = end_q;
    assign bus.busyOUT            = busy_q;
    assign bus.errorOUT           = err_q;
endmodule
